// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: parity modes,
// receiver FSM states and bit-midpoint arithmetic.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;

  function automatic int calc_mid(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Two-flop synchroniser for the serial line plus a three-sample majority
// voter centred on the bit midpoint.
module uart_rx_sampler #(
  parameter int CW = 7
) (
  input  logic          clk_i,
  input  logic          srst_i,
  input  logic          rx_i,
  input  logic [CW-1:0] cnt_i,
  input  logic [CW-1:0] mid_i,
  output logic          rx_sync_o,
  output logic          vote_o,
  output logic          bit_o
);

  logic          sync1_q;
  logic          sync2_q;
  logic [1:0]    samp_q;
  logic          bit_q;
  logic [CW-1:0] mid_m1;
  logic [CW-1:0] mid_p1;

  assign mid_m1 = mid_i - CW'(1);
  assign mid_p1 = mid_i + CW'(1);

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      samp_q  <= 2'b11;
      bit_q   <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      if (cnt_i == mid_m1) samp_q[0] <= sync2_q;
      if (cnt_i == mid_i)  samp_q[1] <= sync2_q;
      if (cnt_i == mid_p1) bit_q     <= vote_o;
    end
  end

  // The third sample is the live synchronised bit, so the vote is already
  // valid during the count MID+1 cycle for decisions taken on that edge.
  assign vote_o    = (samp_q[0] & samp_q[1]) | (samp_q[0] & sync2_q) | (samp_q[1] & sync2_q);
  assign rx_sync_o = sync2_q;
  assign bit_o     = bit_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5-9 data bits, optional parity, 1-2 stop bits,
// majority-voted sampling, with parity/framing error flags per word.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Busy
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int MID = calc_mid(CLKS_PER_BIT);

  localparam logic [CW-1:0] MID_C     = CW'(MID);
  localparam logic [CW-1:0] DEC_C     = CW'(MID + 1);
  localparam logic [CW-1:0] LAST_C    = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_IDX  = BW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = (STOP_BITS == 2);
  localparam logic          HAS_PAR   = (PARITY != PARITY_NONE);
  localparam logic          ODD_PAR   = (PARITY == PARITY_ODD);

  rx_state_e            state_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_idx_q;
  logic                 stop_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_err_q;
  logic                 frm_err_q;
  logic                 dv_q;
  logic [DATA_BITS-1:0] rx_byte_q;
  logic                 par_out_q;
  logic                 frm_out_q;
  logic                 busy_q;

  logic rx_sync;
  logic vote;
  logic bit_val;

  uart_rx_sampler #(
    .CW(CW)
  ) u_sampler (
    .clk_i    (i_Clock),
    .srst_i   (i_Reset),
    .rx_i     (i_Rx_Serial),
    .cnt_i    (cnt_q),
    .mid_i    (MID_C),
    .rx_sync_o(rx_sync),
    .vote_o   (vote),
    .bit_o    (bit_val)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      dv_q       <= 1'b0;
      rx_byte_q  <= '0;
      par_out_q  <= 1'b0;
      frm_out_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      dv_q  <= 1'b0;
      cnt_q <= (cnt_q == LAST_C) ? '0 : cnt_q + CW'(1);
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (!rx_sync) begin
            state_q    <= ST_START;
            busy_q     <= 1'b1;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
          end
        end
        ST_START: begin
          if (cnt_q == DEC_C && vote) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == LAST_C) begin
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          // The voted bit was registered at MID+1; shift it in at end of bit.
          if (cnt_q == LAST_C) begin
            shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
            if (bit_idx_q == LAST_IDX) begin
              state_q <= HAS_PAR ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + BW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (cnt_q == LAST_C) begin
            state_q <= ST_STOP;
            if ((^shift_q ^ bit_val) != ODD_PAR) par_err_q <= 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt_q == DEC_C) begin
            if (stop_idx_q == LAST_STOP) begin
              dv_q      <= 1'b1;
              rx_byte_q <= shift_q;
              par_out_q <= par_err_q;
              frm_out_q <= frm_err_q | ~vote;
              cnt_q     <= '0;
              if (frm_err_q | ~vote) begin
                state_q <= ST_WAIT_IDLE;
              end else begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end
            end else if (!vote) begin
              frm_err_q <= 1'b1;
            end
          end else if (cnt_q == LAST_C) begin
            stop_idx_q <= 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          // Hold off while the line is in break so it cannot retrigger.
          if (rx_sync) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign o_Rx_DV      = dv_q;
  assign o_Rx_Byte    = rx_byte_q;
  assign o_Parity_Err = par_out_q;
  assign o_Frame_Err  = frm_out_q;
  assign o_Busy       = busy_q;

endmodule
